// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the two common data buses among NUM_REQ functional-unit
// result ports. Up to two pending results per cycle are picked in rotating
// round-robin order and registered onto cdb1/cdb2. Consumers see a result one
// cycle after its grant. A bus tag of 0 means "no broadcast".
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   flush             squash: no grants, buses go idle next cycle, rr_ptr -> 0
//   req_valid[i]      requester i has a result pending
//   req_tag, req_value   packed per-requester tag/value (slice i)
//   req_ready[i]      combinational grant; accepted when valid & ready
//   cdb1_*, cdb2_*    registered bus outputs (tag 0 = idle)
module cdb_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TAG_W   = 5,
  parameter int unsigned DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] req_value,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [TAG_W-1:0]          cdb1_tag,
  output logic [DATA_W-1:0]         cdb1_value,
  output logic [TAG_W-1:0]          cdb2_tag,
  output logic [DATA_W-1:0]         cdb2_value
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [TAG_W-1:0]  cdb1_tag_q, cdb1_tag_d;
  logic [DATA_W-1:0] cdb1_value_q, cdb1_value_d;
  logic [TAG_W-1:0]  cdb2_tag_q, cdb2_tag_d;
  logic [DATA_W-1:0] cdb2_value_q, cdb2_value_d;

  logic              found_a, found_b;
  logic [PTR_W-1:0]  idx_a, idx_b, scan_idx;
  logic              gnt_a, gnt_b, block;
  logic [TAG_W-1:0]  tag_a, tag_b;
  logic [DATA_W-1:0] value_a, value_b;

  // Round-robin scan starting at rr_ptr; NUM_REQ is a power of two so the
  // pointer-width addition wraps modulo NUM_REQ on its own.
  always_comb begin
    found_a  = 1'b0;
    found_b  = 1'b0;
    idx_a    = '0;
    idx_b    = '0;
    scan_idx = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      scan_idx = rr_ptr_q + PTR_W'(off);
      if (req_valid[scan_idx]) begin
        if (!found_a) begin
          found_a = 1'b1;
          idx_a   = scan_idx;
        end else if (!found_b) begin
          found_b = 1'b1;
          idx_b   = scan_idx;
        end
      end
    end
  end

  always_comb begin
    block   = reset | flush;
    gnt_a   = found_a & ~block;
    gnt_b   = found_b & ~block;
    tag_a   = req_tag[idx_a*TAG_W +: TAG_W];
    tag_b   = req_tag[idx_b*TAG_W +: TAG_W];
    value_a = req_value[idx_a*DATA_W +: DATA_W];
    value_b = req_value[idx_b*DATA_W +: DATA_W];

    req_ready = '0;
    if (gnt_a) req_ready[idx_a] = 1'b1;
    if (gnt_b) req_ready[idx_b] = 1'b1;

    // A granted tag-0 result still consumes its slot but is broadcast as
    // idle (tag 0, value 0) so no consumer ever observes it.
    cdb1_tag_d   = '0;
    cdb1_value_d = '0;
    if (gnt_a && (tag_a != '0)) begin
      cdb1_tag_d   = tag_a;
      cdb1_value_d = value_a;
    end
    cdb2_tag_d   = '0;
    cdb2_value_d = '0;
    if (gnt_b && (tag_b != '0)) begin
      cdb2_tag_d   = tag_b;
      cdb2_value_d = value_b;
    end

    // Slot B, when granted, is always the later index in scan order.
    rr_ptr_d = rr_ptr_q;
    if (block)      rr_ptr_d = '0;
    else if (gnt_b) rr_ptr_d = idx_b + PTR_W'(1);
    else if (gnt_a) rr_ptr_d = idx_a + PTR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q     <= '0;
      cdb1_tag_q   <= '0;
      cdb1_value_q <= '0;
      cdb2_tag_q   <= '0;
      cdb2_value_q <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      cdb1_tag_q   <= cdb1_tag_d;
      cdb1_value_q <= cdb1_value_d;
      cdb2_tag_q   <= cdb2_tag_d;
      cdb2_value_q <= cdb2_value_d;
    end
  end

  assign cdb1_tag   = cdb1_tag_q;
  assign cdb1_value = cdb1_value_q;
  assign cdb2_tag   = cdb2_tag_q;
  assign cdb2_value = cdb2_value_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic [3:0]   req_valid;
  logic [19:0]  req_tag;
  logic [127:0] req_value;
  logic [3:0]   req_ready;
  logic [4:0]   cdb1_tag;
  logic [31:0]  cdb1_value;
  logic [4:0]   cdb2_tag;
  logic [31:0]  cdb2_value;

  typedef struct {
    string       name;
    logic [4:0]  t1;
    logic [31:0] v1;
    logic [4:0]  t2;
    logic [31:0] v2;
  } bus_exp_t;

  bus_exp_t sb[$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_REQ(4), .TAG_W(5), .DATA_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_tag    (req_tag),
    .req_value  (req_value),
    .req_ready  (req_ready),
    .cdb1_tag   (cdb1_tag),
    .cdb1_value (cdb1_value),
    .cdb2_tag   (cdb2_tag),
    .cdb2_value (cdb2_value)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic pop_and_check();
    bus_exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      chk({e.name, ".cdb1_tag"},   32'(cdb1_tag),   32'(e.t1));
      chk({e.name, ".cdb1_value"}, cdb1_value,      e.v1);
      chk({e.name, ".cdb2_tag"},   32'(cdb2_tag),   32'(e.t2));
      chk({e.name, ".cdb2_value"}, cdb2_value,      e.v2);
    end
  endtask

  // One cycle: drive inputs just after an edge, check the combinational grant,
  // push the expected bus contents, then compare them after the next edge.
  task automatic step(input string name, input logic fl, input logic [3:0] v,
                      input logic [19:0] t, input logic [127:0] d,
                      input logic [3:0] exp_rdy,
                      input logic [4:0] e1t, input logic [31:0] e1v,
                      input logic [4:0] e2t, input logic [31:0] e2v);
    bus_exp_t e;
    flush     = fl;
    req_valid = v;
    req_tag   = t;
    req_value = d;
    #1;
    chk({name, ".req_ready"}, 32'(req_ready), 32'(exp_rdy));
    e.name = name; e.t1 = e1t; e.v1 = e1v; e.t2 = e2t; e.v2 = e2v;
    sb.push_back(e);
    @(posedge clk);
    #1;
    pop_and_check();
  endtask

  localparam logic [19:0]  TAGS_1234 = {5'd4, 5'd3, 5'd2, 5'd1};
  localparam logic [127:0] VALS_1234 = {32'h404, 32'h303, 32'h202, 32'h101};

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    req_valid = 4'b1111;
    req_tag   = TAGS_1234;
    req_value = VALS_1234;

    // Reset with everything valid: no grants, buses cleared.
    @(posedge clk);
    #1;
    chk("reset.req_ready", 32'(req_ready), 32'h0);
    @(posedge clk);
    #1;
    chk("reset.cdb1_tag", 32'(cdb1_tag), 32'h0);
    chk("reset.cdb2_tag", 32'(cdb2_tag), 32'h0);
    chk("reset.cdb1_value", cdb1_value, 32'h0);
    reset = 1'b0;

    // Idle after release: buses stay 0.
    step("idle", 1'b0, 4'b0000, '0, '0, 4'b0000, 5'd0, 32'h0, 5'd0, 32'h0);

    // rr=0, reqs 1 and 2 -> rr becomes 3.
    step("pair12", 1'b0, 4'b0110, {5'd0, 5'd7, 5'd3, 5'd0},
         {32'h0, 32'hB, 32'hA, 32'h0},
         4'b0110, 5'd3, 32'hA, 5'd7, 32'hB);

    // rr=3, only req 1 valid -> cdb1 only; rr becomes 2.
    step("single1", 1'b0, 4'b0010, {5'd0, 5'd0, 5'd9, 5'd0},
         {32'h0, 32'h0, 32'h55, 32'h0},
         4'b0010, 5'd9, 32'h55, 5'd0, 32'h0);

    // rr=2, req2 tag 0 and req3 tag 6: both granted, tag-0 dropped; rr becomes 0.
    step("tag0", 1'b0, 4'b1100, {5'd6, 5'd0, 5'd0, 5'd0},
         {32'h66, 32'h77, 32'h0, 32'h0},
         4'b1100, 5'd0, 32'h0, 5'd6, 32'h66);

    // All four held valid: (1,2), (3,4), (1,2); rr ends at 2.
    step("all_a", 1'b0, 4'b1111, TAGS_1234, VALS_1234, 4'b0011, 5'd1, 32'h101, 5'd2, 32'h202);
    step("all_b", 1'b0, 4'b1111, TAGS_1234, VALS_1234, 4'b1100, 5'd3, 32'h303, 5'd4, 32'h404);
    step("all_c", 1'b0, 4'b1111, TAGS_1234, VALS_1234, 4'b0011, 5'd1, 32'h101, 5'd2, 32'h202);

    // Flush while req 0 (tag 5) valid; bus already holding (1,2) keeps it this cycle.
    flush     = 1'b1;
    req_valid = 4'b0001;
    req_tag   = {5'd0, 5'd0, 5'd0, 5'd5};
    req_value = {32'h0, 32'h0, 32'h0, 32'h5A5};
    #1;
    chk("flush.cdb1_tag_held", 32'(cdb1_tag), 32'd1);
    chk("flush.cdb2_value_held", cdb2_value, 32'h202);
    step("flush", 1'b1, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd5},
         {32'h0, 32'h0, 32'h0, 32'h5A5},
         4'b0000, 5'd0, 32'h0, 5'd0, 32'h0);

    // rr must be 0 after flush (rr=2 would put req3 on cdb1).
    step("post_flush", 1'b0, 4'b1001, {5'd8, 5'd0, 5'd0, 5'd5},
         {32'h888, 32'h0, 32'h0, 32'h5A5},
         4'b1001, 5'd5, 32'h5A5, 5'd8, 32'h888);

    // rr=0 again; single req 2 -> cdb1, rr becomes 3.
    step("single2", 1'b0, 4'b0100, {5'd0, 5'd31, 5'd0, 5'd0},
         {32'h0, 32'hFFFF_0000, 32'h0, 32'h0},
         4'b0100, 5'd31, 32'hFFFF_0000, 5'd0, 32'h0);

    // rr=3: reqs 0,2,3 valid -> order 3,0; req 2 waits.
    step("wrap", 1'b0, 4'b1101, {5'd13, 5'd12, 5'd0, 5'd10},
         {32'hD, 32'hC, 32'h0, 32'hA0},
         4'b1001, 5'd13, 32'hD, 5'd10, 32'hA0);

    // No grant: bus returns to idle.
    step("idle_end", 1'b0, 4'b0000, '0, '0, 4'b0000, 5'd0, 32'h0, 5'd0, 32'h0);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
